// File: rtl/rk_tape_pkg.sv
// rk_tape_pkg
// Shared types and constants for the cassette-tape player.
//   tape_state_t : player state machine encoding
//   LEADER_LEN   : number of 0x00 leader bytes played ahead of a block
//   SYNC_BYTE    : byte that separates the leader from the block body
//   fifo_entry_t : one buffered input byte together with its end-of-block tag
package rk_tape_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LEADER = 2'd1,
      SYNC   = 2'd2,
      DATA   = 2'd3
   } tape_state_t;

   localparam int         LEADER_LEN = 256;
   localparam logic [7:0] SYNC_BYTE  = 8'hE6;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/rk_tape_fifo.sv
// rk_tape_fifo
// Small synchronous FIFO that buffers the incoming byte stream ahead of the
// tape serialiser. DEPTH must be a power of two so that the pointers wrap
// naturally.
// Ports:
//   clk, reset_n    : system clock, synchronous active-low reset
//   wrEn, wrEntry   : push request and the {last, data} entry to store
//   rdEn            : pop request, ignored while empty
//   rdEntry         : entry at the head of the buffer
//   full, empty     : occupancy status
module rk_tape_fifo
   import rk_tape_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wrEn,
   input  fifo_entry_t wrEntry,
   input  logic        rdEn,
   output fifo_entry_t rdEntry,
   output logic        full,
   output logic        empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fifo_entry_t      mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W:0]   count;
   logic             doWrite;
   logic             doRead;

   assign doWrite = wrEn && !full;
   assign doRead  = rdEn && !empty;
   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rdEntry = mem[rdPtr];

   // Storage array: written only on an accepted push. It carries no reset
   // because stale contents are never visible while the count says empty.
   always_ff @(posedge clk) begin
      if (doWrite) begin
         mem[wrPtr] <= wrEntry;
      end
   end

   // Pointer and occupancy bookkeeping. A simultaneous push and pop leaves
   // the count unchanged while both pointers advance.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doWrite) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (doRead) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({doWrite, doRead})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rk_tape_player.sv
// rk_tape_player
// Turns a byte stream into the biphase cassette waveform read by the BIOS
// tape loader through PPA port C bit 4. Each bit is sent MSB first as two
// half-bits: first the inverted bit, then the bit itself. A half-bit lasts
// HALF_TICKS strobes of ce.
// Optional feature macro: RK_TAPE_LEADER_EN. When defined, the player
// generates the 256-byte 0x00 leader and the 0xE6 sync byte itself; when
// undefined, the byte stream is played verbatim.
// Ports:
//   clk, reset_n       : system clock, synchronous active-low reset
//   ce                 : one-clk timing strobe driving the half-bit counter
//   start              : one-cycle pulse that begins a block (ignored when busy)
//   in_data, in_last   : byte to play and its end-of-block tag
//   in_valid, in_ready : producer handshake into the input buffer
//   tape_out           : biphase tape level
//   busy               : a block is playing
//   underrun           : sticky, the buffer ran empty in the middle of a block
module rk_tape_player
   import rk_tape_pkg::*;
#(
   parameter int HALF_TICKS = 741,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ce,
   input  logic       start,
   input  logic [7:0] in_data,
   input  logic       in_last,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tape_out,
   output logic       busy,
   output logic       underrun
);

   localparam int CNT_W = (HALF_TICKS > 1) ? $clog2(HALF_TICKS) : 1;

   tape_state_t      state;
   tape_state_t      nextState;
   logic [CNT_W-1:0] halfCnt;
   logic             secondHalf;
   logic [2:0]       bitIdx;
   logic [7:0]       shiftReg;
   logic             curLast;
   logic             stalled;

   fifo_entry_t      pushEntry;
   fifo_entry_t      fifoHead;
   logic             fifoFull;
   logic             fifoEmpty;

   logic             halfEnd;
   logic             byteEnd;
   logic             popReq;
   logic             loadEn;
   logic [7:0]       loadByte;
   logic             loadLast;
   logic             goIdle;
   logic             goStall;
   logic             setUnderrun;

`ifdef RK_TAPE_LEADER_EN
   logic [7:0]       leaderCnt;
`endif

   assign pushEntry.last = in_last;
   assign pushEntry.data = in_data;

   rk_tape_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wrEn    (in_valid),
      .wrEntry (pushEntry),
      .rdEn    (popReq),
      .rdEntry (fifoHead),
      .full    (fifoFull),
      .empty   (fifoEmpty)
   );

   assign in_ready = !fifoFull;
   assign busy     = (state != IDLE);

   // A half-bit finishes on the strobe that sees the last count value; a
   // byte finishes when that happens on the second half of bit 0. Nothing
   // advances while idle or while waiting on an empty buffer.
   assign halfEnd = ce && (halfCnt == CNT_W'(HALF_TICKS - 1)) && !stalled && (state != IDLE);
   assign byteEnd = halfEnd && secondHalf && (bitIdx == 3'd7);

   // Byte-boundary decisions: what gets loaded into the serialiser next,
   // whether that byte comes out of the buffer, and whether the player has
   // to wait for data or go back to idle. Popping on the same edge that
   // loads the byte keeps consecutive bytes gap-free.
   always_comb begin
      nextState   = state;
      popReq      = 1'b0;
      loadEn      = 1'b0;
      loadByte    = 8'h00;
      loadLast    = 1'b0;
      goIdle      = 1'b0;
      goStall     = 1'b0;
      setUnderrun = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
`ifdef RK_TAPE_LEADER_EN
               nextState = LEADER;
               loadEn    = 1'b1;
               loadByte  = 8'h00;
`else
               nextState = DATA;
               if (!fifoEmpty) begin
                  popReq   = 1'b1;
                  loadEn   = 1'b1;
                  loadByte = fifoHead.data;
                  loadLast = fifoHead.last;
               end else begin
                  goStall = 1'b1;
               end
`endif
            end
         end
`ifdef RK_TAPE_LEADER_EN
         LEADER: begin
            if (byteEnd) begin
               loadEn = 1'b1;
               if (leaderCnt == 8'(LEADER_LEN - 1)) begin
                  nextState = SYNC;
                  loadByte  = SYNC_BYTE;
               end else begin
                  loadByte = 8'h00;
               end
            end
         end
         SYNC: begin
            if (byteEnd) begin
               nextState = DATA;
               if (!fifoEmpty) begin
                  popReq   = 1'b1;
                  loadEn   = 1'b1;
                  loadByte = fifoHead.data;
                  loadLast = fifoHead.last;
               end else begin
                  goStall     = 1'b1;
                  setUnderrun = 1'b1;
               end
            end
         end
`endif
         DATA: begin
            if (stalled) begin
               if (ce && !fifoEmpty) begin
                  popReq   = 1'b1;
                  loadEn   = 1'b1;
                  loadByte = fifoHead.data;
                  loadLast = fifoHead.last;
               end
            end else if (byteEnd) begin
               if (curLast) begin
                  nextState = IDLE;
                  goIdle    = 1'b1;
               end else if (!fifoEmpty) begin
                  popReq   = 1'b1;
                  loadEn   = 1'b1;
                  loadByte = fifoHead.data;
                  loadLast = fifoHead.last;
               end else begin
                  goStall     = 1'b1;
                  setUnderrun = 1'b1;
               end
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Serialiser and half-bit timing. A freshly loaded byte shows its first
   // half-bit (inverted MSB) right away with the counter restarted. Within
   // a bit the second half shows the bit itself; moving to the next bit
   // shifts the byte and shows the inverse of the new MSB. While stalled,
   // the level and the counter simply hold.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         halfCnt    <= '0;
         secondHalf <= 1'b0;
         bitIdx     <= 3'd0;
         shiftReg   <= 8'h00;
         curLast    <= 1'b0;
         stalled    <= 1'b0;
         tape_out   <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state <= nextState;
         if (loadEn) begin
            shiftReg   <= loadByte;
            curLast    <= loadLast;
            bitIdx     <= 3'd0;
            secondHalf <= 1'b0;
            halfCnt    <= '0;
            stalled    <= 1'b0;
            tape_out   <= ~loadByte[7];
         end else if (goIdle) begin
            tape_out   <= 1'b0;
            halfCnt    <= '0;
            secondHalf <= 1'b0;
            bitIdx     <= 3'd0;
            curLast    <= 1'b0;
         end else if (goStall) begin
            stalled <= 1'b1;
            halfCnt <= '0;
         end else if (halfEnd) begin
            halfCnt <= '0;
            if (!secondHalf) begin
               secondHalf <= 1'b1;
               tape_out   <= shiftReg[7];
            end else begin
               secondHalf <= 1'b0;
               bitIdx     <= bitIdx + 3'd1;
               shiftReg   <= {shiftReg[6:0], 1'b0};
               tape_out   <= ~shiftReg[6];
            end
         end else if (ce && (state != IDLE) && !stalled) begin
            halfCnt <= halfCnt + 1'b1;
         end

         if (start && (state == IDLE)) begin
            underrun <= 1'b0;
         end else if (setUnderrun) begin
            underrun <= 1'b1;
         end
      end
   end

`ifdef RK_TAPE_LEADER_EN
   // Counts leader bytes already completed so the last one hands over to
   // the sync byte. It restarts whenever the player is idle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         leaderCnt <= 8'd0;
      end else if (state == IDLE) begin
         leaderCnt <= 8'd0;
      end else if ((state == LEADER) && byteEnd) begin
         leaderCnt <= leaderCnt + 8'd1;
      end
   end
`endif

endmodule
